// File: rtl/rle_field_unpacker_if.sv
// Handshake bundle for the RLE field unpacker:
// host word port, field request port and field result port.
interface rle_field_unpacker_if #(
  parameter int DATA_W  = 32,
  parameter int FIELD_W = 16,
  parameter int OUT_W   = 64
);
  localparam int LEN_W = $clog2(FIELD_W + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              req_valid;
  logic              req_ready;
  logic [LEN_W-1:0]  req_len;
  logic              req_signed;

  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;

  modport master (
    output in_valid, in_data,
    output req_valid, req_len, req_signed,
    output out_ready,
    input  in_ready, req_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data,
    input  req_valid, req_len, req_signed,
    input  out_ready,
    output in_ready, req_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/rle_field_unpacker.sv
// Expands run-length host words into a bit buffer and
// returns MSB-first variable-width fields on request.
module rle_field_unpacker #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 3,
  parameter int FIELD_W  = 16,
  parameter int OUT_W    = 64,
  parameter int BUF_BITS = 128
) (
  input  logic clk,
  input  logic rst,
  rle_field_unpacker_if.slave bus,
  input  logic flush,
  output logic [$clog2(BUF_BITS+1)-1:0] fill,
  output logic err_len
);
  localparam int TOKENS  = DATA_W / (CNT_W + 1);
  localparam int MAX_RUN = TOKENS * ((1 << CNT_W) - 1);
  localparam int LEN_W   = $clog2(FIELD_W + 1);
  localparam int FILL_W  = $clog2(BUF_BITS + 1);
  localparam int PAD     = BUF_BITS - MAX_RUN;

  logic [BUF_BITS-1:0] bits_q;
  logic [FILL_W-1:0]   fill_q;
  logic                out_valid_q;
  logic [OUT_W-1:0]    out_data_q;
  logic                err_q;

  logic [CNT_W:0]      tok;
  logic [MAX_RUN-1:0]  run_bits;
  logic [MAX_RUN-1:0]  run_left;
  logic [FILL_W-1:0]   run_sum;

  // Runs are packed right-aligned, then left-aligned
  // so the first token's bits land just behind old data.
  always_comb begin
    tok      = '0;
    run_bits = '0;
    run_sum  = '0;
    for (int k = 0; k < TOKENS; k++) begin
      tok = bus.in_data[DATA_W-1-k*(CNT_W+1) -: CNT_W+1];
      run_bits = (run_bits << tok[CNT_W-1:0])
               | (tok[CNT_W]
                  ? ((MAX_RUN'(1) << tok[CNT_W-1:0])
                     - MAX_RUN'(1))
                  : '0);
      run_sum = run_sum + FILL_W'(tok[CNT_W-1:0]);
    end
    run_left = run_bits << (FILL_W'(MAX_RUN) - run_sum);
  end

  logic                len_ok;
  logic                in_fire;
  logic                req_fire;
  logic [LEN_W-1:0]    take;
  logic [FIELD_W-1:0]  field;
  logic [OUT_W-1:0]    sext_mask;
  logic [OUT_W-1:0]    result;
  logic [BUF_BITS-1:0] shifted;
  logic [BUF_BITS-1:0] appended;
  logic [BUF_BITS-1:0] bits_next;
  logic [FILL_W-1:0]   fill_next;

  assign len_ok = (bus.req_len != '0)
               && (bus.req_len <= LEN_W'(FIELD_W));

  assign bus.in_ready = !flush
    && (fill_q <= FILL_W'(PAD));

  assign bus.req_ready = !flush
    && (!out_valid_q || bus.out_ready)
    && (!len_ok || fill_q >= FILL_W'(bus.req_len));

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign req_fire = bus.req_valid && bus.req_ready;
  assign take     = (req_fire && len_ok) ? bus.req_len : '0;

  assign field = bits_q[BUF_BITS-1 -: FIELD_W]
              >> (LEN_W'(FIELD_W) - bus.req_len);

  // The field MSB is always the oldest buffered bit.
  assign sext_mask = ~((OUT_W'(1) << bus.req_len)
                       - OUT_W'(1));
  assign result = OUT_W'(field)
    | ((bus.req_signed && bits_q[BUF_BITS-1])
       ? sext_mask : '0);

  assign shifted  = bits_q << take;
  assign appended = {run_left, {PAD{1'b0}}}
                 >> (fill_q - FILL_W'(take));
  assign bits_next = in_fire ? (shifted | appended)
                             : shifted;
  assign fill_next = fill_q - FILL_W'(take)
                   + (in_fire ? run_sum : '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      bits_q      <= '0;
      fill_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (flush) begin
        bits_q <= '0;
        fill_q <= '0;
      end else begin
        bits_q <= bits_next;
        fill_q <= fill_next;
      end
      if (req_fire && len_ok) begin
        out_valid_q <= 1'b1;
        out_data_q  <= result;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (req_fire && !len_ok) begin
        err_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign fill          = fill_q;
  assign err_len       = err_q;
endmodule

// File: tb/tb_rle_field_unpacker.sv
// Scoreboard bench for rle_field_unpacker: directed
// words and field requests with hand-computed results.
module tb_rle_field_unpacker;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] fill;
  logic       err_len;

  rle_field_unpacker_if #(
    .DATA_W(32), .FIELD_W(16), .OUT_W(64)
  ) bus ();

  rle_field_unpacker dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .flush(flush),
    .fill(fill),
    .err_len(err_len)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];
  logic [63:0] mon_exp;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got %0h",
                 bus.out_data);
      end else begin
        mon_exp = sb.pop_front();
        if (bus.out_data !== mon_exp) begin
          errors++;
          $display("FAIL result got %0h want %0h",
                   bus.out_data, mon_exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [31:0] w);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    #1;
    while (!bus.in_ready && n < 50) begin
      cyc();
      n++;
    end
    if (n == 50) begin
      errors++;
      $display("FAIL send_timeout got 0 want 1");
    end else begin
      cyc();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic req(logic [4:0] len, logic sgn,
                     logic [63:0] exp);
    int n = 0;
    bus.req_valid  = 1'b1;
    bus.req_len    = len;
    bus.req_signed = sgn;
    #1;
    while (!bus.req_ready && n < 50) begin
      cyc();
      n++;
    end
    if (n == 50) begin
      errors++;
      $display("FAIL req_timeout got 0 want 1");
    end else begin
      if (len >= 1 && len <= 16) sb.push_back(exp);
      cyc();
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.req_valid  = 1'b0;
    bus.req_len    = 5'd4;
    bus.req_signed = 1'b0;
    bus.out_ready  = 1'b1;
    cyc();
    cyc();
    chk("rst_fill", 64'(fill), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_err", 64'(err_len), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    rst = 1'b1;
    cyc();

    send(32'hF000_0000);
    chk("sx_fill7", 64'(fill), 64'd7);
    req(5'd7, 1'b0, 64'h7F);
    chk("sx_fill0", 64'(fill), 64'd0);
    send(32'hF000_0000);
    req(5'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);

    bus.in_valid   = 1'b1;
    bus.in_data    = 32'h9300_0000;
    bus.req_valid  = 1'b1;
    bus.req_len    = 5'd4;
    bus.req_signed = 1'b0;
    #1;
    chk("same_cycle_req_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    bus.in_valid = 1'b0;
    #1;
    chk("order_fill4", 64'(fill), 64'd4);
    chk("order_req_ready", 64'(bus.req_ready), 64'd1);
    sb.push_back(64'h8);
    cyc();
    bus.req_valid = 1'b0;
    send(32'h9300_0000);
    req(5'd4, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);

    send(32'h7777_7777);
    send(32'h7777_7777);
    chk("bp_fill112", 64'(fill), 64'd112);
    chk("bp_in_ready0", 64'(bus.in_ready), 64'd0);
    req(5'd16, 1'b0, 64'h0);
    chk("bp_fill96", 64'(fill), 64'd96);
    req(5'd16, 1'b0, 64'h0);
    chk("bp_fill80", 64'(fill), 64'd80);
    chk("bp_in_ready80", 64'(bus.in_ready), 64'd0);
    req(5'd16, 1'b0, 64'h0);
    chk("bp_fill64", 64'(fill), 64'd64);
    chk("bp_in_ready64", 64'(bus.in_ready), 64'd1);
    cyc();
    bus.out_ready = 1'b0;
    req(5'd16, 1'b0, 64'h0);
    bus.req_valid = 1'b1;
    #1;
    chk("hold_req_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
    chk("hold_out_data", bus.out_data, 64'h0);
    chk("hold_fill48", 64'(fill), 64'd48);
    bus.req_valid = 1'b0;
    bus.out_ready = 1'b1;
    cyc();

    flush = 1'b1;
    cyc();
    flush = 1'b0;
    send(32'h7777_7777);
    chk("sim_fill56", 64'(fill), 64'd56);
    bus.in_valid   = 1'b1;
    bus.in_data    = 32'hF000_0000;
    bus.req_valid  = 1'b1;
    bus.req_len    = 5'd16;
    bus.req_signed = 1'b0;
    #1;
    chk("sim_in_ready", 64'(bus.in_ready), 64'd1);
    chk("sim_req_ready", 64'(bus.req_ready), 64'd1);
    sb.push_back(64'h0);
    cyc();
    bus.in_valid  = 1'b0;
    bus.req_valid = 1'b0;
    chk("sim_fill47", 64'(fill), 64'd47);
    req(5'd16, 1'b0, 64'h0);
    req(5'd16, 1'b0, 64'h0);
    req(5'd8, 1'b0, 64'h0);
    req(5'd7, 1'b0, 64'h7F);
    chk("sim_fill0", 64'(fill), 64'd0);
    cyc();
    cyc();

    req(5'd0, 1'b0, 64'h0);
    chk("ill0_err", 64'(err_len), 64'd1);
    chk("ill0_out_valid", 64'(bus.out_valid), 64'd0);
    chk("ill0_fill", 64'(fill), 64'd0);
    req(5'd17, 1'b1, 64'h0);
    chk("ill17_err", 64'(err_len), 64'd1);
    chk("ill17_out_valid", 64'(bus.out_valid), 64'd0);
    chk("ill17_fill", 64'(fill), 64'd0);

    bus.out_ready = 1'b0;
    send(32'hFFFF_FFFF);
    req(5'd8, 1'b0, 64'hFF);
    chk("fl_fill48", 64'(fill), 64'd48);
    send(32'h7100_0000);
    chk("fl_fill56", 64'(fill), 64'd56);
    chk("fl_pend_req_ready", 64'(bus.req_ready), 64'd0);
    flush = 1'b1;
    bus.req_len = 5'd0;
    #1;
    chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
    chk("fl_req_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    flush = 1'b0;
    chk("fl_fill0", 64'(fill), 64'd0);
    chk("fl_out_valid", 64'(bus.out_valid), 64'd1);
    chk("fl_out_data", bus.out_data, 64'hFF);
    chk("fl_err_kept", 64'(err_len), 64'd1);
    bus.out_ready = 1'b1;
    cyc();

    send(32'hFFFF_FFFF);
    bus.out_ready = 1'b0;
    req(5'd4, 1'b0, 64'hF);
    chk("mid_out_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hFFFF_FFFF;
    rst = 1'b0;
    cyc();
    bus.in_valid = 1'b0;
    bus.req_len  = 5'd4;
    #1;
    chk("mid_rst_fill", 64'(fill), 64'd0);
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_out_data", bus.out_data, 64'd0);
    chk("mid_rst_err", 64'(err_len), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
    sb.delete();
    bus.out_ready = 1'b1;
    rst = 1'b1;
    cyc();
    cyc();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
